is_uart_ascii_hex_parser: RTL
=============================

// Module: is_uart_ascii_hex_parser
// PURPOSE
//  Reverse path of the UART hex-to-ASCII encoder: takes ASCII bytes from the UART RX path
//  and assembles hex digits into a binary word. Emits the word on a terminator.
//  Flags malformed input. Sits between the UART receiver and the command/register logic.
// PARAMETERS
//  DATA_W   8  byte width (from is_pkg_uart_controller); must be 8
//  NIBBLES  8  max hex digits per word; word width = 4*NIBBLES
// PORTS
//  clk_i         in   1         system clock, all logic on rising edge
//  rstn_i        in   1         asynchronous active-low reset
//  rx_data_i     in   DATA_W    ASCII byte from UART RX
//  rx_valid_i    in   1         rx_data_i valid
//  rx_ready_o    out  1         parser can accept a byte; byte consumed when valid&&ready
//  word_o        out  4*NIBBLES parsed value, right-aligned, zero-extended
//  digits_o      out  $clog2(NIBBLES+1)  number of digits in word_o
//  word_valid_o  out  1         word_o/digits_o valid; held until word_ready_i
//  word_ready_i  in   1         consumer accepts word
//  err_o         out  1         1-cycle pulse on parse error
//  err_code_o    out  2         01 bad char, 10 overflow; held until next error
// BEHAVIOUR
//  - Reset (async, rstn_i=0): state IDLE, acc=0, cnt=0, rx_ready_o=1, word_valid_o=0,
//    word_o=0, digits_o=0, err_o=0, err_code_o=00. Reset mid-word discards partial word.
//  - Digit: '0'-'9' (0x30-0x39), 'A'-'F' (0x41-0x46), 'a'-'f' (0x61-0x66).
//  - Terminator: LF 0x0A, CR 0x0D, space 0x20. All other bytes are bad chars.
//  - FSM:
//    IDLE:   digit -> acc={acc,nib}, cnt=1, ACCUM; terminator ignored (no empty words);
//            bad char -> error(01), SKIP.
//    ACCUM:  digit with cnt<NIBBLES -> shift acc left 4, OR nib, cnt++;
//            digit with cnt==NIBBLES -> error(10), SKIP;
//            terminator -> latch word_o=acc, digits_o=cnt, HOLD; bad char -> error(01), SKIP.
//    HOLD:   rx_ready_o=0, word_valid_o=1, word_o/digits_o stable;
//            word_ready_i=1 -> word_valid_o=0, acc=0, cnt=0, IDLE.
//    SKIP:   discard all bytes until terminator consumed -> acc=0, cnt=0, IDLE.
//  - rx_ready_o=1 in IDLE, ACCUM, SKIP; 0 only in HOLD.
//  - Latency: terminator consumed in cycle N -> word_valid_o=1 in cycle N+1.
//  - Error: err_o=1 for exactly the cycle after the offending byte is consumed;
//    err_code_o updated same edge. Partial acc is dropped.
//  - Bytes with rx_valid_i=0 have no effect; word_ready_i outside HOLD ignored.
// CONFIGURATION
//  IS_HEX_PARSER_PREFIX_EN defined: in ACCUM, 'x'/'X' (0x78/0x58) when cnt==1, acc==0
//    and no prefix yet in this word -> prefix consumed: cnt=0, acc=0, stay ACCUM
//    (ACCUM with cnt=0 then terminator -> error(01), SKIP). Second prefix -> error(01).
//  Not defined: 'x'/'X' is a bad char everywhere (error(01)).
// TESTING
//  - "1A3\r", word_ready_i=1 -> word_o=0x1A3, digits_o=3, word_valid_o 1 cycle after CR.
//  - "ff " -> word_o=0xFF, digits_o=2; leading "\n\n" before it produces no word.
//  - "12G4\n5\n" -> err_o pulse, err_code_o=01 on 'G', no word for "12G4"; then word 0x5.
//  - "123456789\r" (NIBBLES=8) -> err_code_o=10 on '9', no word; following "7\r" -> 0x7.
//  - "AB\r" with word_ready_i=0 for 5 cycles -> rx_ready_o=0, word_o=0xAB stable,
//    released on ready; rstn_i pulse after "AB" (no terminator) then "C\r" -> 0xC.
//  - "0x1f\r": PREFIX_EN -> word_o=0x1F, digits_o=2; without -> err_code_o=01, no word.

Source files
------------

// File: rtl/is_uart_ascii_hex_parser.sv
// -----------------------------------------------------------------------------
// is_uart_ascii_hex_parser
//
// Turns the ASCII byte stream from the UART receiver back into binary words.
// Hex digits ('0'-'9', 'A'-'F', 'a'-'f') are shifted into an accumulator, and a
// terminator (LF, CR or space) hands the word to the command/register logic.
// Malformed input raises a one-cycle error pulse with a sticky error code, and
// the rest of the offending word is dropped up to its terminator.
//
// Parameters
//   DATA_W   byte width of the RX path (must be 8)
//   NIBBLES  maximum hex digits per word; word width is 4*NIBBLES
//
// Ports
//   clk_i         in   system clock, rising edge
//   rstn_i        in   asynchronous active-low reset
//   rx_data_i     in   ASCII byte from UART RX
//   rx_valid_i    in   rx_data_i valid
//   rx_ready_o    out  byte accepted when rx_valid_i && rx_ready_o
//   word_o        out  parsed value, right-aligned, zero-extended
//   digits_o      out  number of hex digits in word_o
//   word_valid_o  out  word_o/digits_o valid, held until word_ready_i
//   word_ready_i  in   consumer accepts the word
//   err_o         out  one-cycle pulse on a parse error
//   err_code_o    out  01 bad char, 10 overflow; held until the next error
//
// Build option
//   IS_HEX_PARSER_PREFIX_EN  accept one "0x"/"0X" prefix at the start of a word
// -----------------------------------------------------------------------------
module is_uart_ascii_hex_parser #(
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned NIBBLES = 8
) (
   input  logic                          clk_i,
   input  logic                          rstn_i,
   input  logic [DATA_W-1:0]             rx_data_i,
   input  logic                          rx_valid_i,
   output logic                          rx_ready_o,
   output logic [4*NIBBLES-1:0]          word_o,
   output logic [$clog2(NIBBLES+1)-1:0]  digits_o,
   output logic                          word_valid_o,
   input  logic                          word_ready_i,
   output logic                          err_o,
   output logic [1:0]                    err_code_o
);

   localparam int unsigned WORD_W = 4 * NIBBLES;
   localparam int unsigned CNT_W  = $clog2(NIBBLES + 1);

   localparam logic [1:0] ERR_BAD_CHAR = 2'b01;
   localparam logic [1:0] ERR_OVERFLOW = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCUM,
      ST_HOLD,
      ST_SKIP
   } state_t;

   state_t              state_q, state_d;
   logic [WORD_W-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [WORD_W-1:0]   word_d;
   logic [CNT_W-1:0]    digits_d;
   logic                err_d;
   logic [1:0]          err_code_d;

   logic                consume;
   logic                is_num;
   logic                is_alpha;
   logic                is_digit;
   logic                is_term;
   logic [3:0]          nib;
   logic                take_prefix;

   // ---------------------------------------------------------------------------
   // Byte classification
   // ---------------------------------------------------------------------------
   always_comb begin
      is_num   = (rx_data_i >= 8'h30) && (rx_data_i <= 8'h39);
      is_alpha = ((rx_data_i >= 8'h41) && (rx_data_i <= 8'h46)) ||
                 ((rx_data_i >= 8'h61) && (rx_data_i <= 8'h66));
      is_digit = is_num || is_alpha;
      is_term  = (rx_data_i == 8'h0A) || (rx_data_i == 8'h0D) ||
                 (rx_data_i == 8'h20);
      // Low nibble of '0'-'9' is the value; 'A'-'F'/'a'-'f' have 1..6 there.
      nib      = is_num ? rx_data_i[3:0] : (rx_data_i[3:0] + 4'd9);
   end

   assign rx_ready_o   = (state_q != ST_HOLD);
   assign word_valid_o = (state_q == ST_HOLD);
   assign consume      = rx_valid_i && rx_ready_o;

   // ---------------------------------------------------------------------------
   // Optional "0x" prefix: only directly after a single leading '0'
   // ---------------------------------------------------------------------------
`ifdef IS_HEX_PARSER_PREFIX_EN
   logic prefix_q, prefix_d;

   assign take_prefix = ((rx_data_i == 8'h78) || (rx_data_i == 8'h58)) &&
                        (cnt_q == CNT_W'(1)) && (acc_q == '0) && !prefix_q;

   always_comb begin
      prefix_d = prefix_q;
      if (state_q != ST_ACCUM) begin
         prefix_d = 1'b0;
      end else if (consume && take_prefix) begin
         prefix_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         prefix_q <= 1'b0;
      end else begin
         prefix_q <= prefix_d;
      end
   end
`else
   assign take_prefix = 1'b0;
`endif

   // ---------------------------------------------------------------------------
   // Next-state / datapath
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      word_d     = word_o;
      digits_d   = digits_o;
      err_d      = 1'b0;
      err_code_d = err_code_o;

      unique case (state_q)
         ST_IDLE: begin
            if (consume) begin
               if (is_digit) begin
                  acc_d   = WORD_W'(nib);
                  cnt_d   = CNT_W'(1);
                  state_d = ST_ACCUM;
               end else if (!is_term) begin
                  acc_d      = '0;
                  cnt_d      = '0;
                  err_d      = 1'b1;
                  err_code_d = ERR_BAD_CHAR;
                  state_d    = ST_SKIP;
               end
            end
         end

         ST_ACCUM: begin
            if (consume) begin
               if (is_digit) begin
                  if (cnt_q == CNT_W'(NIBBLES)) begin
                     acc_d      = '0;
                     cnt_d      = '0;
                     err_d      = 1'b1;
                     err_code_d = ERR_OVERFLOW;
                     state_d    = ST_SKIP;
                  end else begin
                     acc_d = (acc_q << 4) | WORD_W'(nib);
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end else if (is_term) begin
                  // A word holding only a prefix has no digits and is malformed.
                  if (cnt_q == '0) begin
                     acc_d      = '0;
                     err_d      = 1'b1;
                     err_code_d = ERR_BAD_CHAR;
                     state_d    = ST_SKIP;
                  end else begin
                     word_d   = acc_q;
                     digits_d = cnt_q;
                     state_d  = ST_HOLD;
                  end
               end else if (take_prefix) begin
                  acc_d = '0;
                  cnt_d = '0;
               end else begin
                  acc_d      = '0;
                  cnt_d      = '0;
                  err_d      = 1'b1;
                  err_code_d = ERR_BAD_CHAR;
                  state_d    = ST_SKIP;
               end
            end
         end

         ST_HOLD: begin
            if (word_ready_i) begin
               acc_d   = '0;
               cnt_d   = '0;
               state_d = ST_IDLE;
            end
         end

         ST_SKIP: begin
            if (consume && is_term) begin
               acc_d   = '0;
               cnt_d   = '0;
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // State and output registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q    <= ST_IDLE;
         acc_q      <= '0;
         cnt_q      <= '0;
         word_o     <= '0;
         digits_o   <= '0;
         err_o      <= 1'b0;
         err_code_o <= 2'b00;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
         word_o     <= word_d;
         digits_o   <= digits_d;
         err_o      <= err_d;
         err_code_o <= err_code_d;
      end
   end

endmodule
